// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if
//   Bundles the fetch queue's instruction-port handshake, redirect/stall
//   controls and the head-of-queue outputs toward if_id.
//   master : the fetch queue itself (drives request and head outputs)
//   slave  : the environment (memory port, pipe control, if_id)
// Signals
//   inst_req_o    fetch request            inst_addr_o   fetch address
//   inst_gnt_i    request accepted         inst_rvalid_i response valid
//   inst_rdata_i  response word            flush_i       discard + redirect
//   redirect_pc_i new fetch address        stall_i       hold queue head
//   valid_o       head valid               pc_o/inst_o   head address/word
interface if_fetch_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  inst_req_o;
  logic [ADDR_WIDTH-1:0] inst_addr_o;
  logic                  inst_gnt_i;
  logic                  inst_rvalid_i;
  logic [DATA_WIDTH-1:0] inst_rdata_i;
  logic                  flush_i;
  logic [ADDR_WIDTH-1:0] redirect_pc_i;
  logic                  stall_i;
  logic                  valid_o;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic [DATA_WIDTH-1:0] inst_o;

  modport master (
    output inst_req_o, inst_addr_o, valid_o, pc_o, inst_o,
    input  inst_gnt_i, inst_rvalid_i, inst_rdata_i, flush_i, redirect_pc_i, stall_i
  );

  modport slave (
    input  inst_req_o, inst_addr_o, valid_o, pc_o, inst_o,
    output inst_gnt_i, inst_rvalid_i, inst_rdata_i, flush_i, redirect_pc_i, stall_i
  );
endinterface

// File: rtl/if_fetch_queue.sv
// if_fetch_queue
//   Instruction prefetch queue. Issues word fetches from fetch_pc under a
//   credit check (queued + outstanding < DEPTH), records each granted address
//   in order, pairs it with the returning response and queues the pair for
//   if_id. A flush empties the queue, redirects fetch_pc and, if responses
//   are still in flight, drains (drops) them before fetching resumes.
// Ports
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-low reset
//   bus    if_fetch_queue_if.master (instruction port, flush/stall, head out)
//
// state       | meaning
// STATE_FETCH | normal operation: request, accept responses, present head
// STATE_DRAIN | old-path responses still in flight; each one is dropped
module if_fetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic                clk_i,
  input logic                rst_i,
  if_fetch_queue_if.master   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] STATE_FETCH = 1'b0;
  localparam logic [0:0] STATE_DRAIN = 1'b1;

  logic [0:0]            state;
  logic                  active;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [CNT_W-1:0]      count;
  // In FETCH this counts granted-but-unanswered requests; in DRAIN the same
  // register is the discard count, since no new grants can occur there.
  logic [CNT_W-1:0]      outstanding;
  logic [PTR_W-1:0]      q_wr, q_rd;
  logic [PTR_W-1:0]      a_wr, a_rd;

  logic [ADDR_WIDTH-1:0] q_pc   [DEPTH];
  logic [DATA_WIDTH-1:0] q_inst [DEPTH];
  logic [ADDR_WIDTH-1:0] a_addr [DEPTH];

  logic                  in_fetch;
  logic                  credit_ok;
  logic                  req_raw;
  logic                  grant;
  logic                  resp;
  logic                  push;
  logic                  pop;
  logic                  valid;
  logic [CNT_W-1:0]      out_after;

  assign in_fetch  = (state == STATE_FETCH);
  assign credit_ok = ({1'b0, count} + {1'b0, outstanding}) < (CNT_W+1)'(DEPTH);

  // `active` holds requests off during the first cycle after reset release.
  // req_raw is what the port would request ignoring flush; a grant seen in a
  // flush cycle is still counted so its late response gets drained.
  assign req_raw   = active & in_fetch & credit_ok;
  assign grant     = req_raw & bus.inst_gnt_i;
  assign resp      = bus.inst_rvalid_i & (outstanding != '0);
  assign push      = in_fetch & resp & ~bus.flush_i;
  assign valid     = in_fetch & (count != '0);
  assign pop       = valid & ~bus.stall_i & ~bus.flush_i;
  assign out_after = outstanding + CNT_W'(grant) - CNT_W'(resp);

  assign bus.inst_req_o  = req_raw & ~bus.flush_i;
  assign bus.inst_addr_o = fetch_pc;
  assign bus.valid_o     = valid;
  assign bus.pc_o        = valid ? q_pc[q_rd]   : '0;
  assign bus.inst_o      = valid ? q_inst[q_rd] : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= STATE_FETCH;
      active      <= 1'b0;
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      a_wr        <= '0;
      a_rd        <= '0;
    end else begin
      active      <= 1'b1;
      outstanding <= out_after;
      if (bus.flush_i) begin
        fetch_pc <= bus.redirect_pc_i;
        count    <= '0;
        q_wr     <= '0;
        q_rd     <= '0;
        a_wr     <= '0;
        a_rd     <= '0;
        state    <= (out_after != '0) ? STATE_DRAIN : STATE_FETCH;
      end else if (in_fetch) begin
        if (grant) begin
          fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
          a_wr     <= a_wr + 1'b1;
        end
        if (resp) a_rd <= a_rd + 1'b1;
        if (push) q_wr <= q_wr + 1'b1;
        if (pop)  q_rd <= q_rd + 1'b1;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end else if (out_after == '0) begin
        state <= STATE_FETCH;
      end
    end
  end

  // Storage needs no reset: entries are only read when count/outstanding
  // say they were written.
  always_ff @(posedge clk_i) begin
    if (grant && !bus.flush_i) a_addr[a_wr] <= fetch_pc;
    if (push) begin
      q_pc[q_wr]   <= a_addr[a_rd];
      q_inst[q_wr] <= bus.inst_rdata_i;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue
//   Drives if_fetch_queue through directed scenarios and a randomized run,
//   comparing every cycle against a queue-based behavioural model.
module tb_if_fetch_queue;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] RESET_PC = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_fetch_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  if_fetch_queue #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // behavioural model
  bit          m_active;
  bit          m_drain;
  logic [31:0] m_pc;
  int          m_out;
  logic [31:0] m_qpc[$];
  logic [31:0] m_qdata[$];
  logic [31:0] m_addr[$];

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_drain  = 1'b0;
    m_pc     = RESET_PC;
    m_out    = 0;
    m_qpc.delete();
    m_qdata.delete();
    m_addr.delete();
  endtask

  // Called at a negedge; drives inputs, compares, advances one clock edge.
  task automatic step(input bit flush, input logic [31:0] redir, input bit stall,
                      input bit gnt, input bit rv);
    logic [31:0] rdata;
    bit req_raw, exp_req, exp_valid, granted, resp;
    logic [31:0] exp_pc, exp_inst, a;
    rdata = $urandom;
    bus.flush_i       = flush;
    bus.redirect_pc_i = redir;
    bus.stall_i       = stall;
    bus.inst_gnt_i    = gnt;
    bus.inst_rvalid_i = rv;
    bus.inst_rdata_i  = rdata;

    req_raw   = m_active && !m_drain && (m_qpc.size() + m_out < DEPTH);
    exp_req   = req_raw && !flush;
    exp_valid = !m_drain && (m_qpc.size() != 0);
    exp_pc    = exp_valid ? m_qpc[0]   : 32'h0;
    exp_inst  = exp_valid ? m_qdata[0] : 32'h0;

    #1;
    s_req   = bus.inst_req_o;
    s_addr  = bus.inst_addr_o;
    s_valid = bus.valid_o;
    s_pc    = bus.pc_o;
    s_inst  = bus.inst_o;
    chk("inst_req", {31'b0, s_req}, {31'b0, exp_req});
    if (exp_req) chk("inst_addr", s_addr, m_pc);
    chk("valid", {31'b0, s_valid}, {31'b0, exp_valid});
    chk("pc", s_pc, exp_pc);
    chk("inst", s_inst, exp_inst);

    @(posedge clk);
    granted = gnt && req_raw;
    resp    = rv && (m_out > 0);
    if (flush) begin
      if (!m_drain) begin
        m_out = m_out + int'(granted) - int'(resp);
        m_qpc.delete();
        m_qdata.delete();
        m_addr.delete();
      end else begin
        m_out = m_out - int'(resp);
      end
      m_drain = (m_out != 0);
      m_pc    = redir;
    end else if (m_drain) begin
      m_out = m_out - int'(resp);
      if (m_out == 0) m_drain = 1'b0;
    end else begin
      if (exp_valid && !stall) begin
        void'(m_qpc.pop_front());
        void'(m_qdata.pop_front());
      end
      if (resp) begin
        a = m_addr.pop_front();
        m_qpc.push_back(a);
        m_qdata.push_back(rdata);
      end
      if (granted) begin
        m_addr.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
      m_out = m_out + int'(granted) - int'(resp);
    end
    m_active = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; mid=1 asserts reset between clock edges.
  task automatic do_reset(input bit mid);
    if (mid) #3;
    rst_n = 1'b0;
    bus.flush_i = 0; bus.stall_i = 0; bus.inst_gnt_i = 0;
    bus.inst_rvalid_i = 0; bus.inst_rdata_i = 0; bus.redirect_pc_i = 0;
    #1;
    chk("rst_req",   {31'b0, bus.inst_req_o}, 32'h0);
    chk("rst_valid", {31'b0, bus.valid_o},    32'h0);
    chk("rst_pc",    bus.pc_o,   32'h0);
    chk("rst_inst",  bus.inst_o, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit found;
    int gp, sp;
    logic [31:0] r;
    model_reset();
    bus.flush_i = 0; bus.stall_i = 0; bus.inst_gnt_i = 0;
    bus.inst_rvalid_i = 0; bus.inst_rdata_i = 0; bus.redirect_pc_i = 0;
    @(negedge clk);
    do_reset(0);

    // zero-wait stream: head valid from cycle 3, pc 0,4,8,...
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 1, m_out > 0);
      if (i == 0) chk("first_req_low", {31'b0, s_req}, 32'h0);
      if (i == 1) chk("first_req_addr", s_addr, 32'h0);
      if (i < 3)  chk("stream_not_valid", {31'b0, s_valid}, 32'h0);
      else        chk("stream_pc", s_pc, (i - 3) * 4);
    end

    // stall fills exactly DEPTH entries then stops requesting
    do_reset(0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1, m_out > 0);
    chk("stall_req_off", {31'b0, s_req}, 32'h0);
    chk("stall_head", s_pc, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1, m_out > 0);
      chk("stall_pop_pc", s_pc, k * 4);
    end

    // flush with two outstanding -> drain both, then 0x100
    do_reset(0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 32'h100, 0, 0, 0);
    chk("flush_req_low", {31'b0, s_req}, 32'h0);
    step(0, 0, 0, 0, 1);
    chk("drain_valid1", {31'b0, s_valid}, 32'h0);
    step(0, 0, 0, 0, 1);
    chk("drain_valid2", {31'b0, s_valid}, 32'h0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(0, 0, 0, 1, m_out > 0);
      if (s_valid) begin
        found = 1;
        chk("redirect_pc", s_pc, 32'h100);
      end
    end
    chk("redirect_seen", {31'b0, found}, 32'h1);

    // flush, grant and rvalid in the same cycle
    do_reset(0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 32'h200, 0, 1, 1);
    chk("sim_flush_req", {31'b0, s_req}, 32'h0);
    step(0, 0, 0, 1, 1);
    chk("sim_drain_valid", {31'b0, s_valid}, 32'h0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(0, 0, 0, 1, m_out > 0);
      if (s_valid) begin
        found = 1;
        chk("sim_redirect_pc", s_pc, 32'h200);
      end
    end
    chk("sim_redirect_seen", {31'b0, found}, 32'h1);

    // address wrap
    do_reset(0);
    step(1, 32'hFFFF_FFFC, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("wrap_addr_hi", s_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 0);
    chk("wrap_req", {31'b0, s_req}, 32'h1);
    chk("wrap_addr_lo", s_addr, 32'h0);

    // reset mid-burst with three queued entries
    do_reset(0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, m_out > 0);
    step(0, 0, 1, 1, m_out > 0);
    step(0, 0, 1, 0, m_out > 0);
    step(0, 0, 1, 0, m_out > 0);
    chk("burst_valid", {31'b0, s_valid}, 32'h1);
    do_reset(1);
    step(0, 0, 0, 1, 0);
    chk("post_rst_valid0", {31'b0, s_valid}, 32'h0);
    step(0, 0, 0, 1, 0);
    chk("post_rst_req_addr", s_addr, RESET_PC);
    chk("post_rst_valid1", {31'b0, s_valid}, 32'h0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(0, 0, 0, 1, m_out > 0);
      if (s_valid) begin
        found = 1;
        chk("post_rst_first_pc", s_pc, RESET_PC);
      end
    end
    chk("post_rst_seen", {31'b0, found}, 32'h1);

    // randomized run
    do_reset(0);
    for (int i = 0; i < 4000; i++) begin
      gp = ((i / 500) % 2 == 0) ? 100 : 60;
      sp = ((i / 700) % 2 == 0) ? 10 : 50;
      r  = $urandom;
      r[1:0] = 2'b00;
      if ($urandom_range(999) < 2) begin
        do_reset(1);
      end else begin
        step($urandom_range(99) < 4, r, $urandom_range(99) < sp,
             $urandom_range(99) < gp,
             (m_out > 0) ? ($urandom_range(99) < 65) : ($urandom_range(99) < 5));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
